// File: rtl/sub20_serial_pkg.sv
// Shared definitions for the bit-serial subtractor.
//   WIDTH   : default operand/result width, shared with the ripple adder datapath
//   CNT_W   : width of the serial bit counter
//   state_t : FSM state encoding (IDLE / RUN / DONE)
package sub20_serial_pkg;

    localparam int WIDTH = 20;
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/sub20_serial_if.sv
// Handshake and data bundle for the serial subtractor.
//   master : drives start/a/b, observes busy/done/diff/bout/zero/overflow
//   slave  : the subtractor side
interface sub20_serial_if #(
    parameter int WIDTH = sub20_serial_pkg::WIDTH
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             zero;
    logic             overflow;

    modport master (
        output start, a, b,
        input  busy, done, diff, bout, zero, overflow
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, bout, zero, overflow
    );
endinterface

// File: rtl/sub20_serial_full_subtractor.sv
// One-bit full subtractor: d = a - b - bin, with borrow out.
//   a, b : operand bits
//   bin  : borrow in
//   d    : difference bit
//   bout : borrow out
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);
    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/sub20_serial.sv
// Bit-serial subtractor computing a - b, LSB first, one bit per clock through
// a single full-subtractor cell and a borrow flop.
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : slave side of sub20_serial_if
//          start/a/b in; busy, done (1-cycle pulse), diff, bout, zero, overflow out
// Results are published only on entry to DONE and held until the next one.
module sub20_serial
    import sub20_serial_pkg::*;
#(
    parameter int WIDTH = sub20_serial_pkg::WIDTH
) (
    input  logic        clk,
    input  logic        rst,
    sub20_serial_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic             brw;
    // Operand sign bits are kept aside because the shift registers lose them.
    logic             a_msb;
    logic             b_msb;

    logic             d_bit;
    logic             brw_nxt;
    logic [WIDTH-1:0] res_nxt;

    full_subtractor u_fs (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .bin  (brw),
        .d    (d_bit),
        .bout (brw_nxt)
    );

    // Difference bits enter at the MSB so after WIDTH shifts bit 0 lands at LSB.
    assign res_nxt = {d_bit, res_sr[WIDTH-1:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            a_sr         <= '0;
            b_sr         <= '0;
            res_sr       <= '0;
            brw          <= 1'b0;
            a_msb        <= 1'b0;
            b_msb        <= 1'b0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.diff     <= '0;
            bus.bout     <= 1'b0;
            bus.zero     <= 1'b0;
            bus.overflow <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    bus.done <= 1'b0;
                    if (bus.start) begin
                        state    <= ST_RUN;
                        bus.busy <= 1'b1;
                        a_sr     <= bus.a;
                        b_sr     <= bus.b;
                        a_msb    <= bus.a[WIDTH-1];
                        b_msb    <= bus.b[WIDTH-1];
                        cnt      <= '0;
                        brw      <= 1'b0;
                    end else begin
                        state    <= ST_IDLE;
                        bus.busy <= 1'b0;
                    end
                end
                ST_RUN: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    brw    <= brw_nxt;
                    res_sr <= res_nxt;
                    if (cnt == CNT_LAST) begin
                        state        <= ST_DONE;
                        cnt          <= '0;
                        bus.busy     <= 1'b0;
                        bus.done     <= 1'b1;
                        bus.diff     <= res_nxt;
                        bus.bout     <= brw_nxt;
                        bus.zero     <= (res_nxt == '0);
                        bus.overflow <= (a_msb != b_msb) && (res_nxt[WIDTH-1] != a_msb);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    bus.busy <= 1'b0;
                    bus.done <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sub20_serial.sv
module tb_sub20_serial;
    localparam int W = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    int   n;

    sub20_serial_if #(.WIDTH(W)) bus ();

    sub20_serial #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    // Present operands with start for exactly one edge (E0); returns #1 after E0.
    task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv);
        @(negedge clk);
        bus.a     = av;
        bus.b     = bv;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // Counts edges while busy, bounded; returns #1 after the edge that drops busy.
    task automatic wait_done(output int cyc);
        cyc = 0;
        while (bus.busy && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic chk_res(input string tag, input logic [W-1:0] ed, input logic eb,
                           input logic ez, input logic eo);
        chk({tag, "_done"}, 32'(bus.done), 32'd1);
        chk({tag, "_diff"}, 32'(bus.diff), 32'(ed));
        chk({tag, "_bout"}, 32'(bus.bout), 32'(eb));
        chk({tag, "_zero"}, 32'(bus.zero), 32'(ez));
        chk({tag, "_ovf"},  32'(bus.overflow), 32'(eo));
    endtask

    initial begin
        int hold_bad;
        int seen_done;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_diff", 32'(bus.diff), 32'd0);
        chk("rst_flags", {29'd0, bus.bout, bus.zero, bus.overflow}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // 5 - 3
        start_op(20'd5, 20'd3);
        chk("a5_busy_e0", 32'(bus.busy), 32'd1);
        wait_done(n);
        chk("a5_busy_cycles", 32'(n), 32'd20);
        chk_res("a5", 20'h00002, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk("a5_done_pulse", 32'(bus.done), 32'd0);
        chk("a5_diff_hold", 32'(bus.diff), 32'h2);

        // 3 - 5
        start_op(20'd3, 20'd5);
        wait_done(n);
        chk("b3_busy_cycles", 32'(n), 32'd20);
        chk_res("b3", 20'hFFFFE, 1'b1, 1'b0, 1'b0);

        // signed overflow, both directions
        start_op(20'h80000, 20'h00001);
        wait_done(n);
        chk_res("ov1", 20'h7FFFF, 1'b0, 1'b0, 1'b1);
        start_op(20'h7FFFF, 20'hFFFFF);
        wait_done(n);
        chk_res("ov2", 20'h80000, 1'b1, 1'b0, 1'b1);

        // equal operands, then restart in the DONE cycle
        start_op(20'hABCDE, 20'hABCDE);
        wait_done(n);
        chk_res("eq", 20'h00000, 1'b0, 1'b1, 1'b0);
        bus.a     = 20'd10;
        bus.b     = 20'd4;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        chk("bb_busy", 32'(bus.busy), 32'd1);
        chk("bb_done_low", 32'(bus.done), 32'd0);
        hold_bad = 0;
        n = 1;
        while (bus.busy && n < 40) begin
            if (bus.diff !== 20'h0 || bus.zero !== 1'b1) hold_bad++;
            @(posedge clk);
            #1;
            n++;
        end
        chk("bb_hold", 32'(hold_bad), 32'd0);
        chk("bb_gap", 32'(n), 32'd21);
        chk_res("bb", 20'h00006, 1'b0, 1'b0, 1'b0);

        // start during RUN ignored, operand changes ignored
        start_op(20'h12345, 20'h01111);
        repeat (4) @(posedge clk);
        @(negedge clk);
        bus.a     = 20'h0;
        bus.b     = 20'hFFFFF;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a     = 20'h55555;
        wait_done(n);
        chk("ign_busy_cycles", 32'(n + 5), 32'd20);
        chk_res("ign", 20'h11234, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk("ign_no_restart", 32'(bus.busy), 32'd0);

        // async reset mid-RUN
        start_op(20'd7, 20'd2);
        repeat (9) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_busy", 32'(bus.busy), 32'd0);
        chk("ar_done", 32'(bus.done), 32'd0);
        chk("ar_diff", 32'(bus.diff), 32'd0);
        chk("ar_flags", {29'd0, bus.bout, bus.zero, bus.overflow}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen_done = 0;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (bus.done || bus.busy) seen_done++;
        end
        chk("ar_no_done", 32'(seen_done), 32'd0);

        start_op(20'd1, 20'd1);
        wait_done(n);
        chk("post_busy_cycles", 32'(n), 32'd20);
        chk_res("post", 20'h00000, 1'b0, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
